urv_divide_radix: RTL and testbench

//  Parametrised multi-cycle integer divider for the uRV execute stage (RV32M DIV/DIVU/REM/REMU).

---
 rtl/urv_divide_radix.sv | 177 +++++++++++++++++
 tb/tb_urv_divide_radix.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_divide_radix.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Retires G_BITS_PER_CYCLE quotient bits per iteration; div-by-zero/overflow have a fast path.
module urv_divide_radix #(
  parameter int unsigned G_WIDTH          = 32,
  parameter int unsigned G_BITS_PER_CYCLE = 1,
  parameter bit          G_FAST_SPECIAL   = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               x_stall_i,
  input  logic               x_kill_i,
  output logic               x_stall_req_o,
  input  logic               d_valid_i,
  input  logic               d_is_divide_i,
  input  logic [G_WIDTH-1:0] d_rs1_i,
  input  logic [G_WIDTH-1:0] d_rs2_i,
  input  logic [2:0]         d_fun_i,
  output logic [G_WIDTH-1:0] x_rd_o
);

  localparam int unsigned N    = G_WIDTH / G_BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [G_WIDTH-1:0] rs1_q, rs1_d;
  logic [G_WIDTH-1:0] rs2_q, rs2_d;
  logic [G_WIDTH-1:0] n_q, n_d;    // dividend shifts out, quotient shifts in
  logic [G_WIDTH-1:0] d_q, d_d;
  logic [G_WIDTH-1:0] r_q, r_d;
  logic [G_WIDTH-1:0] rd_q, rd_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               signed_q, signed_d;
  logic               is_rem_q, is_rem_d;
  logic               quot_neg_q, quot_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic               ovf_q, ovf_d;

  logic               start;
  logic               busy;
  logic [G_WIDTH:0]   shifted;
  logic [G_WIDTH-1:0] rem_v, num_v;
  logic               unused_fun;

  assign unused_fun = d_fun_i[2];

  assign start = d_valid_i & d_is_divide_i & ~x_stall_i & ~x_kill_i;
  assign busy  = (state_q != StIdle) && (state_q != StDone);

  assign x_stall_req_o = start | (busy & ~x_kill_i);
  assign x_rd_o        = rd_q;

  // One iteration step of restoring division, unrolled G_BITS_PER_CYCLE times.
  always_comb begin
    rem_v   = r_q;
    num_v   = n_q;
    shifted = '0;
    for (int unsigned i = 0; i < G_BITS_PER_CYCLE; i++) begin
      shifted = {rem_v, num_v[G_WIDTH-1]};
      num_v   = num_v << 1;
      if (shifted >= {1'b0, d_q}) begin
        shifted  = shifted - {1'b0, d_q};
        num_v[0] = 1'b1;
      end
      rem_v = shifted[G_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    n_d        = n_q;
    d_d        = d_q;
    r_d        = r_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    is_rem_d   = is_rem_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    div0_d     = div0_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rs1_d    = d_rs1_i;
          rs2_d    = d_rs2_i;
          signed_d = ~d_fun_i[0];
          is_rem_d = d_fun_i[1];
          state_d  = StPrep;
        end
      end
      StPrep: begin
        n_d        = (signed_q && rs1_q[G_WIDTH-1]) ? -rs1_q : rs1_q;
        d_d        = (signed_q && rs2_q[G_WIDTH-1]) ? -rs2_q : rs2_q;
        r_d        = '0;
        quot_neg_d = signed_q & (rs1_q[G_WIDTH-1] ^ rs2_q[G_WIDTH-1]);
        rem_neg_d  = signed_q & rs1_q[G_WIDTH-1];
        div0_d     = (rs2_q == '0);
        ovf_d      = signed_q && (rs1_q == {1'b1, {(G_WIDTH-1){1'b0}}}) && (rs2_q == '1);
        cnt_d      = CntW'(N);
        state_d    = (G_FAST_SPECIAL && (div0_d || ovf_d)) ? StFix : StIter;
      end
      StIter: begin
        n_d   = num_v;
        r_d   = rem_v;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // Special results are raw: the sign correction is skipped for them.
        if (div0_q) begin
          rd_d = is_rem_q ? rs1_q : '1;
        end else if (ovf_q) begin
          rd_d = is_rem_q ? '0 : rs1_q;
        end else if (is_rem_q) begin
          rd_d = rem_neg_q ? -r_q : r_q;
        end else begin
          rd_d = quot_neg_q ? -n_q : n_q;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (busy && x_kill_i) begin
      state_d = StIdle;
      rd_d    = rd_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rs1_q      <= '0;
      rs2_q      <= '0;
      n_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      is_rem_q   <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      n_q        <= n_d;
      d_q        <= d_d;
      r_q        <= r_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      is_rem_q   <= is_rem_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      div0_q     <= div0_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_urv_divide_radix.sv
// Scoreboard bench for urv_divide_radix: three configurations driven in lockstep,
// each with its own expected-result queue popped by a monitor on the DONE cycle.
module tb_urv_divide_radix;

  localparam logic [2:0] FDIV  = 3'b100;
  localparam logic [2:0] FDIVU = 3'b101;
  localparam logic [2:0] FREM  = 3'b110;
  localparam logic [2:0] FREMU = 3'b111;

  typedef struct {
    string       name;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        x_stall;
  logic        x_kill;
  logic        d_valid;
  logic        d_is_div;
  logic [31:0] d_rs1;
  logic [31:0] d_rs2;
  logic [2:0]  d_fun;
  logic        stall_req [3];
  logic [31:0] rd        [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int          n_checks;
  int          n_errors;
  logic [31:0] last_res;

  urv_divide_radix #(.G_WIDTH(32), .G_BITS_PER_CYCLE(1), .G_FAST_SPECIAL(1'b1)) u_div_b1 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
    .x_stall_req_o(stall_req[0]), .d_valid_i(d_valid), .d_is_divide_i(d_is_div),
    .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .d_fun_i(d_fun), .x_rd_o(rd[0])
  );

  urv_divide_radix #(.G_WIDTH(32), .G_BITS_PER_CYCLE(2), .G_FAST_SPECIAL(1'b1)) u_div_b2 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
    .x_stall_req_o(stall_req[1]), .d_valid_i(d_valid), .d_is_divide_i(d_is_div),
    .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .d_fun_i(d_fun), .x_rd_o(rd[1])
  );

  urv_divide_radix #(.G_WIDTH(32), .G_BITS_PER_CYCLE(4), .G_FAST_SPECIAL(1'b0)) u_div_b4 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
    .x_stall_req_o(stall_req[2]), .d_valid_i(d_valid), .d_is_divide_i(d_is_div),
    .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .d_fun_i(d_fun), .x_rd_o(rd[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] fun, input logic [31:0] a,
                                        input logic [31:0] b);
    if (b == 32'h0) return fun[1] ? a : 32'hFFFF_FFFF;
    if (!fun[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return fun[1] ? 32'h0 : a;
    case (fun[1:0])
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Present one start cycle in IDLE; operands are scrambled afterwards.
  task automatic drive(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    d_valid  = 1'b1;
    d_is_div = 1'b1;
    d_fun    = fun;
    d_rs1    = a;
    d_rs2    = b;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    d_fun   = 3'b000;
    d_rs1   = 32'hDEAD_BEEF;
    d_rs2   = 32'hCAFE_F00D;
  endtask

  task automatic wait_empty(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: %0d/%0d/%0d results outstanding, required 0",
               name, q0.size(), q1.size(), q2.size());
      q0.delete();
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic issue(input string name, input logic [2:0] fun, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit ext_stall);
    bit   sp;
    exp_t e;
    sp     = (b == 32'h0) || (!fun[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    e.name = name;
    e.val  = exp;
    e.cyc  = sp ? 3 : 35;
    q0.push_back(e);
    e.cyc  = sp ? 3 : 19;
    q1.push_back(e);
    e.cyc  = 11;
    q2.push_back(e);
    drive(fun, a, b);
    if (ext_stall) begin
      x_stall = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      x_stall = 1'b0;
    end
    wait_empty(name);
    last_res = exp;
  endtask

  // Monitor: the DONE cycle is where the stall request falls without a kill.
  initial begin : monitor
    int   hi_cnt [3];
    bit   prev   [3];
    bit   have;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      hi_cnt[i] = 0;
      prev[i]   = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          hi_cnt[i] = 0;
          prev[i]   = 1'b0;
        end else begin
          if (stall_req[i]) begin
            hi_cnt[i]++;
          end else begin
            if (prev[i] && !x_kill) begin
              have = 1'b0;
              case (i)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
              endcase
              n_checks++;
              if (!have) begin
                n_errors++;
                $display("FAIL unexpected completion dut%0d: result %h, none required", i, rd[i]);
              end else begin
                if (rd[i] !== e.val) begin
                  n_errors++;
                  $display("FAIL %s dut%0d result: got %h, required %h", e.name, i, rd[i], e.val);
                end
                n_checks++;
                if (hi_cnt[i] != e.cyc) begin
                  n_errors++;
                  $display("FAIL %s dut%0d stall cycles: got %0d, required %0d",
                           e.name, i, hi_cnt[i], e.cyc);
                end
              end
            end
            hi_cnt[i] = 0;
          end
          prev[i] = stall_req[i];
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    logic [31:0] corner [4];
    n_checks = 0;
    n_errors = 0;
    last_res = 32'h0;
    rst      = 1'b1;
    x_stall  = 1'b0;
    x_kill   = 1'b0;
    d_valid  = 1'b0;
    d_is_div = 1'b0;
    d_fun    = 3'b000;
    d_rs1    = 32'h0;
    d_rs2    = 32'h0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset rd dut%0d", i), rd[i], 32'h0);
      check($sformatf("reset stall dut%0d", i), {31'h0, stall_req[i]}, 32'h0);
    end
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    issue("divu 100/7",      FDIVU, 32'd100,        32'd7,          32'd14,         1'b0);
    issue("remu 100%7",      FREMU, 32'd100,        32'd7,          32'd2,          1'b0);
    issue("rem -7%2",        FREM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0);
    issue("div -7/2",        FDIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0);
    issue("div 7/-2",        FDIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0);
    issue("rem 7%-2",        FREM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0);
    issue("div -100/7",      FDIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0);
    issue("rem -100%7",      FREM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0);
    issue("div x/0",         FDIV,  32'h1234_5678,  32'h0,          32'hFFFF_FFFF,  1'b0);
    issue("rem x/0",         FREM,  32'h1234_5678,  32'h0,          32'h1234_5678,  1'b0);
    issue("divu x/0",        FDIVU, 32'h1234_5678,  32'h0,          32'hFFFF_FFFF,  1'b0);
    issue("remu x/0",        FREMU, 32'h1234_5678,  32'h0,          32'h1234_5678,  1'b0);
    issue("div ovf",         FDIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0);
    issue("rem ovf",         FREM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b0);
    issue("divu min/ones",   FDIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b0);
    issue("remu min/ones",   FREMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0);
    issue("divu ones/1",     FDIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0);
    issue("div -1/-1",       FDIV,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0);
    issue("divu ones/ones",  FDIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0);
    issue("div 0/5",         FDIV,  32'd0,          32'd5,          32'd0,          1'b0);
    issue("divu 9/3 xstall", FDIVU, 32'd9,          32'd3,          32'd3,          1'b1);

    // Kill in the 6th iteration cycle of every configuration.
    issue("divu 50/7",       FDIVU, 32'd50,         32'd7,          32'd7,          1'b0);
    drive(FDIVU, 32'd1000, 32'd7);
    repeat (6) @(posedge clk);
    #1;
    x_kill = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("kill stall dut%0d", i), {31'h0, stall_req[i]}, 32'h0);
    end
    @(posedge clk);
    #1;
    x_kill = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("kill rd dut%0d", i), rd[i], last_res);
      check($sformatf("post-kill stall dut%0d", i), {31'h0, stall_req[i]}, 32'h0);
    end
    issue("divu 9/3 after kill", FDIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // Asynchronous reset mid-iteration, away from any clock edge.
    drive(FDIV, 32'd12345, 32'd67);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async rst rd dut%0d", i), rd[i], 32'h0);
      check($sformatf("async rst stall dut%0d", i), {31'h0, stall_req[i]}, 32'h0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    last_res = 32'h0;

    corner[0] = 32'h0;
    corner[1] = 32'h1;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    for (int k = 0; k < 16; k++) begin
      rf = {1'b1, 2'($urandom_range(0, 3))};
      ra = (k % 4 == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rb = (k % 3 == 0) ? corner[$urandom_range(0, 2)] : $urandom;
      if (k % 5 == 1) rb = rb >> $urandom_range(4, 28);
      issue($sformatf("rand%0d f%0b %h/%h", k, rf, ra, rb), rf, ra, rb, model(rf, ra, rb), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
